// File: rtl/riscky_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: word width, byte stride,
// FSM state encodings and the payload address helper.
package riscky_loader_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_t;

    // Byte address of payload word 'index' relative to the image base.
    function automatic logic [WORD_W-1:0] word_byte_addr(
        input logic [WORD_W-1:0] base,
        input logic [WORD_W-1:0] index
    );
        return base + (index * WORD_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/loader_csum.sv
// Running 32-bit wrap-around sum of the payload words, with synchronous clear and an
// equality compare against the trailing checksum word presented on the same data bus.
module loader_csum
    import riscky_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add,
    input  logic [WORD_W-1:0] data,
    output logic              match
);

    logic [WORD_W-1:0] sum_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg <= '0;
        end else if (clear) begin
            sum_reg <= '0;
        end else if (add) begin
            sum_reg <= sum_reg + data;
        end
    end

    assign match = (sum_reg == data);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length-prefixed word stream, writes the
// payload to memory and holds the core in reset until done. Optional feature: CHECKSUM_EN.
module imem_loader
    import riscky_loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [WORD_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [WORD_W-1:0] CAPACITY = WORD_W'(1) << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    load_state_t       state_reg;
    load_state_t       state_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   len_reg;
    logic              s_ready_reg;
    logic              mem_we_reg;
    logic [WORD_W-1:0] mem_addr_reg;
    logic [WORD_W-1:0] mem_wdata_reg;
    logic              core_rst_n_reg;
    logic              done_reg;
    logic              error_reg;

    logic              fire;
    logic [ADDR_W:0]   count_inc;
    logic              last_word;
    logic              len_zero;
    logic              len_too_big;
    logic              restart;
    logic [WORD_W-1:0] write_addr;

    assign fire        = s_valid & s_ready_reg;
    assign count_inc   = count_reg + CNT_ONE;
    assign last_word   = (count_inc == len_reg);
    assign len_zero    = (s_data == '0);
    assign len_too_big = (s_data > CAPACITY);
    assign write_addr  = word_byte_addr(BASE_ADDR, WORD_W'(count_reg));
    assign restart     = ((state_reg == ST_DONE) || (state_reg == ST_ERROR)) && start;

`ifdef CHECKSUM_EN
    localparam load_state_t ST_AFTER_PAYLOAD = ST_CSUM;

    logic csum_clear;
    logic csum_add;
    logic csum_match;

    assign csum_clear = (state_reg == ST_LEN) && fire;
    assign csum_add   = (state_reg == ST_LOAD) && fire;

    loader_csum u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clear),
        .add   (csum_add),
        .data  (s_data),
        .match (csum_match)
    );
`else
    localparam load_state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LEN: begin
                if (fire) begin
                    if (len_zero) begin
                        state_next = ST_AFTER_PAYLOAD;
                    end else if (len_too_big) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (fire && last_word) begin
                    state_next = ST_AFTER_PAYLOAD;
                end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (fire) begin
                    state_next = csum_match ? ST_DONE : ST_ERROR;
                end
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_LEN;
                end
            end
            default: state_next = ST_LEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_LEN;
            count_reg      <= '0;
            len_reg        <= '0;
            s_ready_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            core_rst_n_reg <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_ready_reg <= (state_next == ST_LEN) || (state_next == ST_LOAD) ||
                           (state_next == ST_CSUM);
            done_reg    <= (state_next == ST_DONE);
            error_reg   <= (state_next == ST_ERROR);
            // Release only from the second DONE cycle, so the final write has retired.
            core_rst_n_reg <= (state_reg == ST_DONE) && (state_next == ST_DONE);
            mem_we_reg     <= (state_reg == ST_LOAD) && fire;

            if ((state_reg == ST_LEN) && fire && !len_too_big) begin
                len_reg <= s_data[ADDR_W:0];
            end

            if ((state_reg == ST_LOAD) && fire) begin
                mem_addr_reg  <= write_addr;
                mem_wdata_reg <= s_data;
                count_reg     <= count_inc;
            end else if (restart) begin
                count_reg <= '0;
            end
        end
    end

    assign s_ready      = s_ready_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign core_rst_n   = core_rst_n_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign words_loaded = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expectations come from an image-level
// model (writes list, final status, word count) built from the stream contents.
module tb_imem_loader;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam logic [31:0] CAP    = 32'd1 << ADDR_W;

    logic            clk;
    logic            rst;
    logic            start;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_data;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            core_rst_n;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int overlap  = 0;
    logic prev_crst = 1'b0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    int          rise_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            obs_cyc.push_back(cycle);
            if (core_rst_n) overlap <= overlap + 1;
        end
        if (core_rst_n && !prev_crst) rise_q.push_back(cycle);
        prev_crst <= core_rst_n;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sum_q(input logic [31:0] q[$]);
        logic [31:0] s = 32'h0;
        foreach (q[k]) s = s + q[k];
        return s;
    endfunction

    task automatic push_word(input logic [31:0] w, input int idle);
        int t;
        if (idle > 0) begin
            s_valid = 1'b0;
            repeat (idle) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        while (!s_ready && t < 200) begin @(posedge clk); #1; t++; end
        check("ready_wait", 64'(t < 200), 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_core_rst_n", core_rst_n, 0);
        check("restart_done", done, 0);
        check("restart_error", error, 0);
        check("restart_count", words_loaded, 0);
        check("restart_ready", s_ready, 1);
    endtask

    task automatic run_image(input string name, input logic [31:0] n_len,
                             input logic [31:0] pay[$], input logic [31:0] csum_word,
                             input int gap_mode, input bit want_consec, input bit start_mid);
        bit          too_big;
        bit          exp_err;
        int          exp_n;
        int          t;
        logic [31:0] exp_addr;
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); rise_q.delete();
        too_big = (n_len > CAP);
        exp_n   = too_big ? 0 : int'(n_len);
        exp_err = too_big;
`ifdef CHECKSUM_EN
        if (!too_big && sum_q(pay) != csum_word) exp_err = 1'b1;
`endif
        push_word(n_len, 0);
        if (!too_big) begin
            foreach (pay[k]) begin
                push_word(pay[k], (gap_mode == 2) ? 1 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0);
                if (start_mid && k == 0 && pay.size() > 1) begin
                    start = 1'b1;
                    @(posedge clk); #1;
                    start = 1'b0;
                    check("mid_start_count", words_loaded, 1);
                    check("mid_start_ready", s_ready, 1);
                    check("mid_start_done", done, 0);
                end
            end
`ifdef CHECKSUM_EN
            push_word(csum_word, (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0);
`endif
        end
        t = 0;
        while (!(done || error) && t < 100) begin @(posedge clk); #1; t++; end
        check("status_wait", 64'(t < 100), 1);
        repeat (2) begin @(posedge clk); #1; end

        check("nwrites", obs_addr.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            if (i < obs_addr.size()) begin
                exp_addr = BASE + 32'(4 * i);
                check("waddr", obs_addr[i], exp_addr);
                check("wdata", obs_data[i], pay[i]);
                if (want_consec && i > 0) check("consecutive", obs_cyc[i] - obs_cyc[i-1], 1);
            end
        end
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("core_rst_n", core_rst_n, !exp_err);
        check("words_loaded", words_loaded, exp_n);
        check("ready_idle", s_ready, 0);
        if (!exp_err && exp_n > 0) begin
            check("release_once", rise_q.size(), 1);
            if (rise_q.size() > 0 && obs_cyc.size() > 0) begin
`ifdef CHECKSUM_EN
                check("release_after_write", 64'(rise_q[0] > obs_cyc[obs_cyc.size()-1]), 1);
`else
                check("release_timing", rise_q[0] - obs_cyc[obs_cyc.size()-1], 1);
`endif
            end
        end
        $display("IMAGE %s n=%0d writes=%0d done=%0b error=%0b core_rst_n=%0b",
                 name, n_len, obs_addr.size(), done, error, core_rst_n);
    endtask

    initial begin
        logic [31:0] pay[$];
        logic [31:0] n;
        logic [31:0] cs;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", words_loaded, 0);
        check("rst_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        pay.delete(); pay.push_back(32'h0050_0093); pay.push_back(32'h00A0_0113); pay.push_back(32'h0020_81B3);
        run_image("basic3", 3, pay, sum_q(pay), 0, 1, 0);

        pulse_start();
        pay.delete(); pay.push_back(32'hDEAD_BEEF); pay.push_back(32'h1234_5678);
        run_image("toggle2", 2, pay, sum_q(pay), 2, 0, 0);

        pulse_start();
        pay.delete();
        run_image("empty", 0, pay, 32'h0, 0, 0, 0);

        pulse_start();
        run_image("too_big", CAP + 1, pay, 32'h0, 0, 0, 0);

`ifdef CHECKSUM_EN
        pulse_start();
        pay.delete(); pay.push_back(32'hFFFF_FFFF); pay.push_back(32'h0000_0002);
        run_image("csum_ok", 2, pay, 32'h0000_0001, 0, 0, 0);
        pulse_start();
        run_image("csum_bad", 2, pay, 32'h0000_0002, 0, 0, 0);
`endif

        pulse_start();
        push_word(32'd4, 0);
        push_word(32'hAAAA_0001, 0);
        push_word(32'hAAAA_0002, 0);
        rst = 1'b0;
        #1;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_core_rst_n", core_rst_n, 0);
        check("midrst_done", done, 0);
        check("midrst_count", words_loaded, 0);
        check("midrst_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        pay.delete(); pay.push_back(32'h5555_AAAA);
        run_image("fresh_after_rst", 1, pay, sum_q(pay), 0, 0, 0);

        pulse_start();
        pay.delete(); pay.push_back(32'h0000_0011); pay.push_back(32'h0000_0022); pay.push_back(32'h0000_0033);
        run_image("start_in_load", 3, pay, sum_q(pay), 0, 0, 1);

        pulse_start();
        pay.delete(); pay.push_back(32'hC0DE_0001);
        run_image("reload1", 1, pay, sum_q(pay), 0, 0, 0);

        pulse_start();
        pay.delete();
        for (int k = 0; k < int'(CAP); k++) pay.push_back($urandom);
        run_image("full_capacity", CAP, pay, sum_q(pay), 0, 1, 0);

        for (int r = 0; r < 8; r++) begin
            pulse_start();
            pay.delete();
            if ($urandom_range(0, 5) == 0) begin
                n = CAP + 32'd1 + 32'($urandom_range(0, 100));
            end else begin
                n = 32'($urandom_range(0, 8));
                for (int k = 0; k < int'(n); k++) pay.push_back($urandom);
            end
            cs = sum_q(pay);
            if ($urandom_range(0, 3) == 0) cs = cs + 32'd1 + 32'($urandom_range(0, 5));
            run_image($sformatf("rand%0d", r), n, pay, cs, 1, 0, 0);
        end

        check("no_release_during_write", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
